// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller and the load-use comparator.
//                  hazard_state_t : sequencer states (RUN, MEM_WAIT, ERROR)
//                  stage_ctrl_t   : per pipeline register {en, flush} pair
//                  REG_ZERO       : architectural x0 register index
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational comparator between the source registers of the
//                ID instruction and the destination of the EX instruction.
//                Per-operand match flags are exported so the forwarding unit
//                can reuse the same comparator.
//  Ports       : ex_mem_read_i  EX instruction is a load
//                ex_rd_i        EX destination register
//                id_rs1_i/rs2_i ID source registers
//                id_uses_rs1_i/rs2_i  ID instruction reads the operand
//                rs1_match_o/rs2_match_o  operand depends on ex_rd (x0 excluded)
//                hazard_o       load-use hazard: a stall bubble is required
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       rs1_match_o,
    output logic       rs2_match_o,
    output logic       hazard_o
);

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    logic w_rd_valid;
    assign w_rd_valid = (ex_rd_i != REG_ZERO);

    assign rs1_match_o = w_rd_valid & id_uses_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_match_o = w_rd_valid & id_uses_rs2_i & (id_rs2_i == ex_rd_i);
    assign hazard_o    = ex_mem_read_i & (rs1_match_o | rs2_match_o);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for the five-stage core. Detects
//                load-use hazards, flushes on M-stage jumps, runs the data
//                memory handshake with timeout, and keeps saturating
//                stall / flush performance counters.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                id_rs1/rs2, id_uses_*    ID operand info
//                ex_rd, ex_mem_read       EX destination / load flag
//                m_mem_read/write         M-stage memory operation
//                m_take_jump              M-stage taken branch / jump
//                dmem_ready / dmem_req    data memory handshake
//                pc_en, *_en, *_flush     pipeline register controls
//                mem_error                sticky timeout flag
//                stall_cnt, flush_cnt     saturating performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             m_mem_read,
    input  logic             m_mem_write,
    input  logic             m_take_jump,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_m_en,
    output logic             m_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_m_flush,
    output logic             m_wb_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    stage_ctrl_t w_if_id, w_id_ex, w_ex_m, w_m_wb;
    logic        w_pc_en;
    logic        w_dmem_req;
    logic        w_flush_inc;
    logic        w_advance;
    logic        w_mem_op;
    logic        w_load_use;
    logic        w_rs1_match;
    logic        w_rs2_match;

    assign w_mem_op = m_mem_read | m_mem_write;

    load_use_detect u_load_use_detect (
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .rs1_match_o   (w_rs1_match),
        .rs2_match_o   (w_rs2_match),
        .hazard_o      (w_load_use)
    );

    // ------------------------------------------------------------------
    // Next state and pipeline controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        w_advance   = 1'b0;
        w_flush_inc = 1'b0;
        w_dmem_req  = 1'b0;
        w_pc_en     = 1'b1;
        w_if_id     = '{en: 1'b1, flush: 1'b0};
        w_id_ex     = '{en: 1'b1, flush: 1'b0};
        w_ex_m      = '{en: 1'b1, flush: 1'b0};
        w_m_wb      = '{en: 1'b1, flush: 1'b0};

        unique case (state_q)
            RUN: begin
                w_dmem_req = w_mem_op;
                if (w_mem_op && !dmem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    w_advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d   = RUN;
                    wait_d    = '0;
                    w_advance = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                // Trapped: only reset leaves this state.
                state_d  = ERROR;
                w_pc_en  = 1'b0;
                w_if_id  = '{en: 1'b0, flush: 1'b0};
                w_id_ex  = '{en: 1'b0, flush: 1'b0};
                w_ex_m   = '{en: 1'b0, flush: 1'b0};
                w_m_wb   = '{en: 1'b0, flush: 1'b0};
            end
        endcase

        if (state_q != ERROR) begin
            if (!w_advance) begin
                // Waiting on memory: freeze the front of the pipe and push a
                // bubble into WB. A pending jump is deferred to the ready cycle.
                w_pc_en      = 1'b0;
                w_if_id.en   = 1'b0;
                w_id_ex.en   = 1'b0;
                w_ex_m.en    = 1'b0;
                w_m_wb.flush = 1'b1;
            end else if (m_take_jump) begin
                // Redirect wins over load-use: the dependent instruction is
                // squashed by the flush anyway.
                w_if_id.flush = 1'b1;
                w_id_ex.flush = 1'b1;
                w_ex_m.flush  = 1'b1;
                w_flush_inc   = 1'b1;
            end else if (w_load_use) begin
                // Hold PC and IF/ID one cycle, bubble into EX; the load itself
                // moves on to M so the hazard clears after one cycle.
                w_pc_en       = 1'b0;
                w_if_id.en    = 1'b0;
                w_id_ex.flush = 1'b1;
            end
        end

        if (rst) begin
            state_d    = RUN;
            wait_d     = '0;
            w_dmem_req = 1'b0;
            w_pc_en    = 1'b0;
            w_if_id    = '{en: 1'b0, flush: 1'b1};
            w_id_ex    = '{en: 1'b0, flush: 1'b1};
            w_ex_m     = '{en: 1'b0, flush: 1'b1};
            w_m_wb     = '{en: 1'b0, flush: 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // State, wait counter and saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!w_pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (w_flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign dmem_req    = w_dmem_req;
    assign pc_en       = w_pc_en;
    assign if_id_en    = w_if_id.en;
    assign id_ex_en    = w_id_ex.en;
    assign ex_m_en     = w_ex_m.en;
    assign m_wb_en     = w_m_wb.en;
    assign if_id_flush = w_if_id.flush;
    assign id_ex_flush = w_id_ex.flush;
    assign ex_m_flush  = w_ex_m.flush;
    assign m_wb_flush  = w_m_wb.flush;
    assign mem_error   = (state_q == ERROR);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl. Control outputs
//                are packed as {pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
//                if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush, dmem_req}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    localparam logic [9:0] V_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] V_LU    = 10'b00111_0100_0;
    localparam logic [9:0] V_JMP   = 10'b11111_1110_0;
    localparam logic [9:0] V_RST   = 10'b00000_1111_0;
    localparam logic [9:0] V_FRZ   = 10'b00000_0001_1;
    localparam logic [9:0] V_ERR   = 10'b00000_0000_0;
    localparam logic [9:0] M_ALL   = 10'b11111_1111_1;
    localparam logic [9:0] M_NOMWB = 10'b11110_1111_1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic             m_mem_read, m_mem_write, m_take_jump, dmem_ready;
    logic             dmem_req, pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en;
    logic             if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush, mem_error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
        .m_take_jump(m_take_jump), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en),
        .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_m_en(ex_m_en), .m_wb_en(m_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_m_flush(ex_m_flush), .m_wb_flush(m_wb_flush),
        .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, ld, jmp;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [9:0] ctl();
        return {pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
                if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush, dmem_req};
    endfunction

    task automatic chk_ctl(input string nm, input logic [9:0] exp, input logic [9:0] mask);
        logic [9:0] act;
        act = ctl();
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: ctl got %b want %b (mask %b)", nm, act, exp, mask);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs are combinational; sample mid-cycle on the falling edge.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        m_mem_read = 1'b0; m_mem_write = 1'b0; m_take_jump = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"no_load",   5'd5,  5'd0, 5'd5,  1, 0, 0, 0, V_RUN};
        vecs[1] = '{"lu_rs1",    5'd5,  5'd0, 5'd5,  1, 0, 1, 0, V_LU};
        vecs[2] = '{"x0_load",   5'd0,  5'd0, 5'd0,  1, 1, 1, 0, V_RUN};
        vecs[3] = '{"lu_rs2",    5'd1,  5'd7, 5'd7,  0, 1, 1, 0, V_LU};
        vecs[4] = '{"rs2_unused",5'd1,  5'd7, 5'd7,  1, 0, 1, 0, V_RUN};
        vecs[5] = '{"rs1_unused",5'd7,  5'd1, 5'd7,  0, 1, 1, 0, V_RUN};
        vecs[6] = '{"jmp_lu",    5'd5,  5'd0, 5'd5,  1, 0, 1, 1, V_JMP};
        vecs[7] = '{"jmp_only",  5'd2,  5'd3, 5'd9,  1, 1, 0, 1, V_JMP};
        vecs[8] = '{"no_match",  5'd3,  5'd4, 5'd6,  1, 1, 1, 0, V_RUN};
        vecs[9] = '{"lu_r31",    5'd31, 5'd0, 5'd31, 1, 0, 1, 0, V_LU};

        idle_inputs();
        rst = 1'b1;

        // Reset state
        sample();
        chk_ctl("reset_outputs", V_RST, M_ALL);
        step();
        rst = 1'b0;
        sample();
        chk_val("reset_stall_cnt", int'(stall_cnt), 0);
        chk_val("reset_flush_cnt", int'(flush_cnt), 0);
        chk_val("reset_mem_error", int'(mem_error), 0);
        chk_ctl("reset_first_run", V_RUN, M_ALL);

        // Table-driven single-cycle vectors (state stays RUN)
        for (int i = 0; i < 10; i++) begin
            step();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
            id_uses_rs1 = vecs[i].use1; id_uses_rs2 = vecs[i].use2;
            ex_mem_read = vecs[i].ld; m_take_jump = vecs[i].jmp;
            sample();
            chk_ctl(vecs[i].name, vecs[i].exp, M_ALL);
        end
        step();
        idle_inputs();
        sample();
        chk_val("table_stall_cnt", int'(stall_cnt), 3);
        chk_val("table_flush_cnt", int'(flush_cnt), 2);

        // Load-use: one bubble, then the load has moved to M
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        sample();
        chk_ctl("lu_seq_stall", V_LU, M_ALL);
        step();
        ex_mem_read = 1'b0;
        sample();
        chk_ctl("lu_seq_resume", V_RUN, M_ALL);
        chk_val("lu_seq_stall_cnt", int'(stall_cnt), 1);
        step();
        idle_inputs();

        // Memory wait of 3 cycles with a deferred jump
        do_reset();
        m_mem_read = 1'b1; m_take_jump = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk_ctl($sformatf("memwait_frozen%0d", c), V_FRZ, M_NOMWB);
            step();
        end
        dmem_ready = 1'b1;
        sample();
        chk_ctl("memwait_ready", V_JMP | 10'b1, M_ALL);
        step();
        idle_inputs();
        sample();
        chk_ctl("memwait_after", V_RUN, M_ALL);
        chk_val("memwait_stall_cnt", int'(stall_cnt), 3);
        chk_val("memwait_flush_cnt", int'(flush_cnt), 1);

        // Timeout into ERROR, counter saturation, reset recovery
        do_reset();
        m_mem_write = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk_ctl($sformatf("timeout_frozen%0d", c), V_FRZ, M_NOMWB);
            chk_val($sformatf("timeout_noerr%0d", c), int'(mem_error), 0);
            step();
        end
        sample();
        chk_ctl("error_outputs", V_ERR, M_ALL);
        chk_val("error_flag", int'(mem_error), 1);
        dmem_ready = 1'b1;
        for (int c = 0; c < 14; c++) step();
        sample();
        chk_ctl("error_held", V_ERR, M_ALL);
        chk_val("error_flag_sticky", int'(mem_error), 1);
        chk_val("stall_cnt_saturated", int'(stall_cnt), 15);
        step();
        rst = 1'b1;
        sample();
        chk_ctl("error_reset_outputs", V_RST, M_ALL);
        step();
        rst = 1'b0;
        idle_inputs();
        sample();
        chk_val("error_cleared", int'(mem_error), 0);
        chk_val("error_reset_stall_cnt", int'(stall_cnt), 0);
        chk_ctl("error_post_reset_run", V_RUN, M_ALL);

        // Reset in the middle of MEM_WAIT
        step();
        m_mem_read = 1'b1;
        step();
        step();
        rst = 1'b1;
        sample();
        chk_ctl("midwait_reset_outputs", V_RST, M_ALL);
        step();
        rst = 1'b0;
        idle_inputs();
        sample();
        chk_val("midwait_stall_cnt", int'(stall_cnt), 0);
        chk_val("midwait_flush_cnt", int'(flush_cnt), 0);
        chk_ctl("midwait_post_reset_run", V_RUN, M_ALL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage RISC-V core's segmented registers (IF/ID, ID/EX, EX/M, M/WB).
- Detects load-use hazards in ID.
- Acts on jumps/branches resolved in the M stage.
- Runs the data-memory request/ready handshake for M-stage loads and stores, with a timeout.
- Drives per-register enable and flush lines, plus saturating performance counters.

Parameters:
MEM_TIMEOUT, 64, max wait cycles for dmem_ready before the error trap
CNT_W, 16, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
m_mem_read  in  1  M-stage load (from EX/M register)
m_mem_write  in  1  M-stage store
m_take_jump  in  1  M-stage branch taken or forced jump
dmem_ready  in  1  data memory completes current access
dmem_req  out  1  data memory access request
pc_en  out  1  PC update enable
if_id_en, id_ex_en, ex_m_en, m_wb_en  out  1 each  pipeline register load enables
if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush  out  1 each  load bubble (all controls 0)
mem_error  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  jumps taken

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- During rst=1:
  - All *_en = 0; all *_flush = 1; dmem_req = 0.
  - State = RUN; wait counter, stall_cnt, flush_cnt and mem_error all cleared on the next edge.
- FSM states: RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs; state and counters are registered.
- mem_op = m_mem_read | m_mem_write. dmem_req = mem_op in RUN or MEM_WAIT; 0 in ERROR.
- Transfer rule: an access completes in the cycle dmem_req & dmem_ready.
- RUN, mem_op & !dmem_ready:
  - Go to MEM_WAIT and load wait counter = 1.
  - Freeze: pc_en, if_id_en, id_ex_en, ex_m_en = 0.
  - m_wb_flush = 1 (bubble into WB).
- MEM_WAIT, !dmem_ready:
  - Hold the freeze; increment wait counter.
  - When wait counter = MEM_TIMEOUT-1, go to ERROR.
- MEM_WAIT, dmem_ready: return to RUN. This cycle behaves as the RUN advance case, including any pending jump or load-use action.
- Advance case (RUN with !mem_op or dmem_ready, or MEM_WAIT with dmem_ready), in priority order:
  - m_take_jump:
    - pc_en = 1; if_id_flush = id_ex_flush = ex_m_flush = 1; m_wb_en = 1.
    - flush_cnt++. The load-use check is suppressed.
  - Load-use: ex_mem_read & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)):
    - pc_en = 0; if_id_en = 0; id_ex_flush = 1; ex_m_en = 1; m_wb_en = 1.
    - Exactly one bubble: the load moves to M next cycle and the hazard clears.
  - Otherwise all *_en = 1 and all flushes = 0.
- Jump and memory-wait priority: a jump with mem_op pending and !dmem_ready defers the flush until the ready cycle. Jumps are not mem ops; this is defensive only.
- ERROR:
  - All *_en = 0; all flushes = 0; dmem_req = 0; mem_error = 1.
  - Exit only via rst.
- Counters: stall_cnt increments in every non-reset cycle with pc_en = 0. Both counters saturate at all-ones; no wrap.
- Flush wins over enable for the same register. Register behaviour when en = 0 and flush = 0 is hold.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - enum hazard_state_t {RUN, MEM_WAIT, ERROR}.
  - Struct stage_ctrl_t {en, flush}.
  - Constant REG_ZERO = 5'd0.
- Sub-module load_use_detect: purely combinational comparator on rs1/rs2/ex_rd. It is also reused by the forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; stall_cnt=1.
- x0 load: same as the load-use case but ex_rd=0 -> no stall; all en=1.
- Jump plus load-use: m_take_jump=1 with a simultaneous load-use match -> if_id/id_ex/ex_m_flush=1, pc_en=1, no stall, flush_cnt=1.
- Memory wait: m_mem_read=1, dmem_ready low for 3 cycles then high:
  - 3 cycles frozen with m_wb_flush=1 and dmem_req=1.
  - 4th cycle all en=1; stall_cnt=3.
- Timeout with MEM_TIMEOUT=4: dmem_ready held low -> ERROR after 4 wait cycles; mem_error=1, dmem_req=0, everything held; rst=1 for one cycle clears it; first post-reset cycle in RUN.
- Reset mid-MEM_WAIT: rst asserted -> all flush=1 and en=0 that cycle; counters read 0 after the edge.
